// File: rtl/serial_capture_fifo_pkg.sv
// Shared definitions for the serial capture buffer: bit-order encodings
// used to select the shift direction of the deserialiser.
package serial_capture_fifo_pkg;

  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

endpackage

// File: rtl/serial_capture_fifo_sync_fifo.sv
// Synchronous FIFO with a registered head word and an occupancy count.
// The head register holds its last value while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [LVL_W-1:0] level_q;
  logic [WIDTH-1:0] head_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty      = (level_q == '0);
  assign full       = (level_q == LVL_W'(DEPTH));
  assign pop_ok     = pop && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_ok    = push && (!full || pop_ok);
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  assign rd_data = head_q;
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr_inc;
      end

      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase

      // Head is the next stored entry, or the incoming word when it is the only one.
      if (pop_ok) begin
        if (level_q == LVL_W'(1)) begin
          if (push_ok) begin
            head_q <= wr_data;
          end
        end else begin
          head_q <= mem[rd_ptr_inc];
        end
      end else if (empty && push_ok) begin
        head_q <= wr_data;
      end
    end
  end

endmodule

// File: rtl/serial_capture_fifo.sv
// Serial deserialiser with manual/automatic word capture into a FIFO,
// a sticky overflow flag and a live view of the shift register.
module serial_capture_fifo
  import serial_capture_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int AUTO_STORE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  input  logic                         store,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  input  logic                         ovf_clr,
  output logic [WIDTH-1:0]             current_shift
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
  localparam bit SHIFT_ORDER = (MSB_FIRST != 0) ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;
  localparam bit AUTO_EN     = (AUTO_STORE != 0);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_next;
  logic [CNT_W-1:0] bit_cnt;
  logic             overflow_q;
  logic             capture;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  always_comb begin
    shift_next = shift_q;
    if (bit_valid) begin
      if (SHIFT_ORDER == ORDER_MSB_FIRST) begin
        shift_next = {shift_q[WIDTH-2:0], bit_in};
      end else begin
        shift_next = {bit_in, shift_q[WIDTH-1:1]};
      end
    end
  end

  // Manual and automatic capture in the same cycle collapse into one push.
  assign capture   = store || (AUTO_EN && bit_valid && (bit_cnt == CNT_MAX));
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = capture && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      overflow_q <= 1'b0;
    end else begin
      shift_q <= shift_next;

      if (capture) begin
        bit_cnt <= '0;
      end else if (bit_valid) begin
        bit_cnt <= (bit_cnt == CNT_MAX) ? '0 : bit_cnt + CNT_W'(1);
      end

      if (drop) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (capture),
    .wr_data (shift_next),
    .pop     (pop),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign overflow      = overflow_q;
  assign current_shift = shift_q;

endmodule
